// File: rtl/hydra_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hydra_pkg
//  Description : Shared types, sizes and helpers for the hydra per-port
//                queue scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package hydra_pkg;

  localparam int NUM_PRIO = 8;   // priority queues per output port, 7 highest
  localparam int PRIO_W   = 3;   // width of a priority index
  localparam int CREDIT_W = 4;   // WRR credit width, must hold NUM_PRIO

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

  // WRR weight of queue p: higher priority queues earn more packets per round.
  function automatic logic [CREDIT_W-1:0] wrr_weight(input logic [PRIO_W-1:0] p);
    return CREDIT_W'(p) + CREDIT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_rotate_pick.sv
`default_nettype none
// ============================================================================
//  Module      : prio_rotate_pick
//  Description : Combinational rotating priority encoder. Scans the request
//                vector downward starting at i_start (inclusive), wrapping
//                from 0 to NUM_PRIO-1, and reports the first set bit.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_rotate_pick
  import hydra_pkg::*;
(
  input  logic [NUM_PRIO-1:0] i_req,
  input  logic [PRIO_W-1:0]   i_start,
  output logic                o_found,
  output logic [PRIO_W-1:0]   o_idx
);

  // Walk i_start, i_start-1, ... (mod NUM_PRIO) and latch the first requester.
  always_comb begin
    logic [PRIO_W-1:0] w_cand;
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      w_cand = i_start - PRIO_W'(i);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_wrr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : port_wrr_scheduler
//  Description : Per-output-port queue scheduler. Picks one of NUM_PRIO
//                priority queues per grant using strict priority or weighted
//                round robin, and tracks the granted packet until its EOP.
//  Revision    : 1.0  initial release
// ============================================================================
module port_wrr_scheduler
  import hydra_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wrr_enable,
  input  logic [NUM_PRIO-1:0] i_queue_nonempty,
  input  logic                i_ready,
  input  logic                i_pkt_done,
  output logic                o_grant_vld,
  output logic [PRIO_W-1:0]   o_grant_prio,
  output logic                o_busy
);

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;
  logic [PRIO_W-1:0]   r_rr_ptr;
  logic [PRIO_W-1:0]   r_grant_prio;
  logic                r_wrr_prev;

  logic                w_idle;
  logic                w_wrr_rise;
  logic                w_start;
  logic                w_reload;
  logic [PRIO_W-1:0]   w_ptr_eff;
  logic [NUM_PRIO-1:0] w_elig;
  logic [NUM_PRIO-1:0] w_a_req;
  logic [PRIO_W-1:0]   w_a_start;
  logic                w_a_found;
  logic [PRIO_W-1:0]   w_a_idx;
  logic                w_b_found;
  logic [PRIO_W-1:0]   w_b_idx;
  logic [PRIO_W-1:0]   w_pick;

  assign w_idle     = (r_state == IDLE);
  // Enabling WRR while idle starts a fresh round; selection in that same
  // cycle already sees the fresh credits and pointer.
  assign w_wrr_rise = w_idle && i_wrr_enable && !r_wrr_prev;
  assign w_ptr_eff  = w_wrr_rise ? PRIO_W'(NUM_PRIO - 1) : r_rr_ptr;
  assign w_start    = w_idle && i_ready && (|i_queue_nonempty);

  // Primary scan: strict priority from the top, or WRR over eligible queues
  // starting at the round-robin pointer.
  assign w_a_req   = i_wrr_enable ? w_elig    : i_queue_nonempty;
  assign w_a_start = i_wrr_enable ? w_ptr_eff : PRIO_W'(NUM_PRIO - 1);

  prio_rotate_pick u_pick_main (
    .i_req   (w_a_req),
    .i_start (w_a_start),
    .o_found (w_a_found),
    .o_idx   (w_a_idx)
  );

  // Fallback scan over the reloaded credit set: every credit is non-zero after
  // a reload, so eligibility collapses to non-empty.
  prio_rotate_pick u_pick_reload (
    .i_req   (i_queue_nonempty),
    .i_start (w_ptr_eff),
    .o_found (w_b_found),
    .o_idx   (w_b_idx)
  );

  assign w_reload = i_wrr_enable && !w_a_found && w_b_found;
  assign w_pick   = w_reload ? w_b_idx : w_a_idx;

  // Per-queue credit counters and their eligibility.
  for (genvar p = 0; p < NUM_PRIO; p++) begin : g_credit
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_eff;
    logic [CREDIT_W-1:0] w_credit_base;

    assign w_credit_eff  = w_wrr_rise ? wrr_weight(PRIO_W'(p)) : r_credit;
    assign w_elig[p]     = i_queue_nonempty[p] && (w_credit_eff != '0);
    assign w_credit_base = (w_wrr_rise || w_reload) ? wrr_weight(PRIO_W'(p)) : r_credit;

    // Charge the picked queue one credit per WRR grant; never wraps below 0.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_credit <= wrr_weight(PRIO_W'(p));
      end else if (w_idle) begin
        if (w_start && i_wrr_enable) begin
          if ((w_pick == PRIO_W'(p)) && (w_credit_base != '0)) begin
            r_credit <= w_credit_base - CREDIT_W'(1);
          end else begin
            r_credit <= w_credit_base;
          end
        end else if (w_wrr_rise) begin
          r_credit <= wrr_weight(PRIO_W'(p));
        end
      end
    end
  end

  // Selection bookkeeping: grant index, WRR pointer and the idle-sampled mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_prio <= '0;
      r_rr_ptr     <= PRIO_W'(NUM_PRIO - 1);
      r_wrr_prev   <= 1'b0;
    end else if (w_idle) begin
      r_wrr_prev <= i_wrr_enable;
      if (w_start) begin
        r_grant_prio <= w_pick;
        if (i_wrr_enable) begin
          r_rr_ptr <= w_pick;
        end
      end else if (w_wrr_rise) begin
        r_rr_ptr <= PRIO_W'(NUM_PRIO - 1);
      end
    end
  end

  // Grant FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state outputs; ready and pkt_done only matter in
  // IDLE and BUSY respectively.
  always_comb begin
    w_state_nxt = r_state;
    o_grant_vld = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        o_grant_vld = 1'b1;
        o_busy      = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: begin
        o_busy = 1'b1;
        if (i_pkt_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_grant_prio = r_grant_prio;

endmodule
`default_nettype wire

// File: tb/tb_port_wrr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_port_wrr_scheduler
//  Description : Self-checking bench for port_wrr_scheduler: a behavioural
//                model checked every cycle plus directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_port_wrr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrr = 1'b0;
  logic       ready = 1'b0;
  logic       pkt_done = 1'b0;
  logic [7:0] ne = 8'h00;
  logic       vld;
  logic [2:0] prio;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;
  int glog[$];

  always #5 clk = ~clk;

  port_wrr_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .i_wrr_enable     (wrr),
    .i_queue_nonempty (ne),
    .i_ready          (ready),
    .i_pkt_done       (pkt_done),
    .o_grant_vld      (vld),
    .o_grant_prio     (prio),
    .o_busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for a request, 1 grant cycle, 2 packet in flight
  int m_phase = 0;
  int m_prio  = 0;
  int m_ptr   = 7;
  int m_cred[8];
  bit m_prev  = 1'b0;

  initial for (int p = 0; p < 8; p++) m_cred[p] = p + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_prio = 0; m_ptr = 7; m_prev = 1'b0;
      for (int p = 0; p < 8; p++) m_cred[p] = p + 1;
    end else begin
      case (m_phase)
        0: begin
          if (wrr && !m_prev) begin
            for (int p = 0; p < 8; p++) m_cred[p] = p + 1;
            m_ptr = 7;
          end
          m_prev = wrr;
          if (ready && ne != 8'h00) begin
            if (!wrr) begin
              for (int p = 0; p < 8; p++) if (ne[p]) m_prio = p;
            end else begin
              int order[8];
              bit any;
              any = 1'b0;
              for (int k = 0; k < 8; k++) order[k] = (m_ptr - k + 8) % 8;
              for (int p = 0; p < 8; p++) if (ne[p] && m_cred[p] > 0) any = 1'b1;
              if (!any) for (int p = 0; p < 8; p++) m_cred[p] = p + 1;
              begin
                bit got;
                got = 1'b0;
                for (int k = 0; k < 8; k++)
                  if (!got && ne[order[k]] && m_cred[order[k]] > 0) begin
                    got = 1'b1; m_prio = order[k];
                  end
              end
              if (m_cred[m_prio] > 0) m_cred[m_prio]--;
              m_ptr = m_prio;
            end
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: if (pkt_done) m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_vld",  {31'd0, vld},  (m_phase == 1) ? 32'd1 : 32'd0);
      chk("model_busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
      chk("model_prio", {29'd0, prio}, m_prio);
      if (vld === 1'b1) glog.push_back(int'(prio));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(1); n++; end
    chk("grant_timeout", {31'd0, busy}, 32'd1);
  endtask

  task automatic packet(input int len);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    wait_busy();
    step(len);
    pkt_done = 1'b1;
    step(1);
    pkt_done = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int base;
  int e3[9] = '{7, 7, 7, 7, 7, 7, 7, 7, 0};

  initial begin
    // 1: reset with random inputs
    @(posedge clk);
    #1 cmp_on = 1'b1;
    repeat (2) begin
      #1;
      wrr = 1'($urandom); ne = 8'($urandom); ready = 1'($urandom); pkt_done = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst_vld",  {31'd0, vld},  32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_prio", {29'd0, prio}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; wrr = 1'b0; ne = 8'h00; ready = 1'b0; pkt_done = 1'b0;
    step(2);

    // 2: strict priority, queues 5 and 3 pending
    wrr = 1'b0; ne = 8'b0010_1000; ready = 1'b1;
    step(1);
    ready = 1'b0;
    @(negedge clk);
    chk("t2_vld",  {31'd0, vld},  32'd1);
    chk("t2_prio", {29'd0, prio}, 32'd5);
    @(negedge clk);
    chk("t2_vld_pulse", {31'd0, vld},  32'd0);
    chk("t2_busy",      {31'd0, busy}, 32'd1);
    repeat (8) @(posedge clk);
    #2 pkt_done = 1'b1;
    step(1);
    pkt_done = 1'b0;
    @(negedge clk);
    chk("t2_busy_off", {31'd0, busy}, 32'd0);
    step(1);

    // 3: WRR with queues 7 and 0 pending
    wrr = 1'b1; ne = 8'b1000_0001;
    base = glog.size();
    for (int i = 0; i < 18; i++) packet(2);
    chk("t3_count", glog.size() - base, 32'd18);
    for (int i = 0; i < 9; i++) chk($sformatf("t3_seq%0d", i), glog[base + i], e3[i]);

    // 4: ready held through BUSY, pkt_done in IDLE
    wrr = 1'b0; ne = 8'h08;
    base = glog.size();
    ready = 1'b1;
    step(1);
    wait_busy();
    step(4);
    ready = 1'b0;
    step(1);
    pkt_done = 1'b1;
    step(1);
    pkt_done = 1'b0;
    step(1);
    chk("t4_one_grant", glog.size() - base, 32'd1);
    chk("t4_prio", glog[glog.size() - 1], 32'd3);
    pkt_done = 1'b1;
    step(3);
    pkt_done = 1'b0;
    @(negedge clk);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_no_extra",  glog.size() - base, 32'd1);
    step(1);

    // 5: reset while a packet is in flight
    wrr = 1'b1; ne = 8'h40; ready = 1'b1;
    step(1);
    ready = 1'b0;
    wait_busy();
    step(2);
    rst = 1'b1;
    #1;
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_vld",  {31'd0, vld},  32'd0);
    step(2);
    rst = 1'b0; ne = 8'h01;
    packet(2);
    chk("t5_prio0", glog[glog.size() - 1], 32'd0);
    ne = 8'h03;
    packet(2);
    chk("t5_credit0_spent", glog[glog.size() - 1], 32'd1);

    // 6: request with nothing queued, then a queue appears
    wrr = 1'b0; ne = 8'h00; ready = 1'b1;
    base = glog.size();
    step(3);
    @(negedge clk);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    chk("t6_no_grant",  glog.size() - base, 32'd0);
    ne = 8'h10;
    @(negedge clk);
    chk("t6_vld",  {31'd0, vld},  32'd1);
    chk("t6_prio", {29'd0, prio}, 32'd4);
    ready = 1'b0;
    step(2);
    pkt_done = 1'b1;
    step(1);
    pkt_done = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
